// File: rtl/udc_job_sequencer.sv
// Bus-master job sequencer for the 8-bit up/down counter: queues jobs, programs and verifies
// PLR/ULR/LLR/CCR, fires start, waits for end-of-cycle and reports per-job status.
module udc_job_sequencer #(
    parameter int unsigned DEPTH   = 2,
    parameter logic [15:0] TIMEOUT = 16'd65535,
    parameter bit          VERIFY  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       job_valid,
    output logic       job_ready,
    input  logic [7:0] job_plr,
    input  logic [7:0] job_ulr,
    input  logic [7:0] job_llr,
    input  logic [7:0] job_ccr,
    input  logic       abort,
    output logic [7:0] udc_dout,
    output logic       udc_doe,
    input  logic [7:0] udc_din,
    output logic       udc_ncs,
    output logic       udc_nrd,
    output logic       udc_nwr,
    output logic       udc_a1,
    output logic       udc_a0,
    output logic       udc_start,
    output logic       udc_reset,
    input  logic       udc_ec,
    input  logic       udc_err,
    output logic       busy,
    output logic       job_done,
    output logic       job_fail,
    output logic [1:0] fail_code
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    typedef enum logic [3:0] {
        StIdle, StCheck, StWrite, StGap, StRead, StStart, StWaitEc, StDone, StFail
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [15:0]   timer_q, timer_d;
    logic [16:0]   timer_inc;
    logic [1:0]    fail_code_q, fail_code_d;
    logic [31:0]   job_q, job_d;
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          udc_reset_q;
    logic          push, pop, full, empty;
    logic [1:0]    sel;
    logic [7:0]    sel_byte;

    // Job queue
    assign full      = (count_q == FullCount);
    assign empty     = (count_q == '0);
    assign pop       = (state_q == StIdle) && !empty;
    assign job_ready = !full || pop;
    assign push      = job_valid && job_ready;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {job_plr, job_ulr, job_llr, job_ccr};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      count_q <= count_q + (AW + 1)'(1);
            else if (pop && !push) count_q <= count_q - (AW + 1)'(1);
        end
    end

    // Register select: write phase steps one register per cycle, read phase one per two cycles
    assign sel = (state_q == StRead) ? cnt_q[2:1] : cnt_q[1:0];

    always_comb begin
        sel_byte = job_q[7:0];
        unique case (sel)
            2'd0: sel_byte = job_q[31:24];
            2'd1: sel_byte = job_q[23:16];
            2'd2: sel_byte = job_q[15:8];
            2'd3: sel_byte = job_q[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            timer_q     <= '0;
            fail_code_q <= '0;
            job_q       <= '0;
            udc_reset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            fail_code_q <= fail_code_d;
            job_q       <= job_d;
            udc_reset_q <= (state_d != StFail);
        end
    end

    assign timer_inc = {1'b0, timer_q} + 17'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        fail_code_d = fail_code_q;
        job_d       = job_q;
        case (state_q)
            StIdle: begin
                if (pop) begin
                    job_d       = mem_q[rd_ptr_q];
                    fail_code_d = 2'b00;
                    state_d     = StCheck;
                end
            end
            StCheck: begin
                if (job_q[31:24] < job_q[15:8] || job_q[31:24] > job_q[23:16]) begin
                    fail_code_d = 2'b01;
                    state_d     = StFail;
                end else begin
                    cnt_d   = '0;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q[1:0] == 2'd3) state_d = StGap;
            end
            StGap: begin
                cnt_d = '0;
                if (VERIFY)                state_d = StRead;
                else if (job_q[7:0] == '0) state_d = StDone;
                else                       state_d = StStart;
            end
            StRead: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q[0]) begin
                    if (udc_din != sel_byte) begin
                        fail_code_d = 2'b10;
                        state_d     = StFail;
                    end else if (cnt_q == 3'd7) begin
                        state_d = (job_q[7:0] == '0) ? StDone : StStart;
                    end
                end
            end
            StStart: begin
                timer_d = 16'd1;
                state_d = StWaitEc;
            end
            StWaitEc: begin
                timer_d = timer_inc[15:0];
                if (udc_ec) begin
                    state_d = StDone;
                end else if (udc_err) begin
                    fail_code_d = 2'b01;
                    state_d     = StFail;
                end else if (timer_inc >= {1'b0, TIMEOUT}) begin
                    fail_code_d = 2'b11;
                    state_d     = StFail;
                end
            end
            StDone: state_d = StIdle;
            StFail: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q[0]) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Abort wins over everything, except once the job has already been resolved
        if (abort && state_q != StIdle && state_q != StDone && state_q != StFail) begin
            fail_code_d = 2'b11;
            state_d     = StFail;
        end
        if (state_d == StFail && state_q != StFail) cnt_d = '0;
    end

    always_comb begin
        udc_ncs   = 1'b1;
        udc_nrd   = 1'b1;
        udc_nwr   = 1'b1;
        udc_doe   = 1'b0;
        udc_dout  = '0;
        udc_a1    = 1'b0;
        udc_a0    = 1'b0;
        udc_start = 1'b0;
        job_done  = 1'b0;
        job_fail  = 1'b0;
        case (state_q)
            StWrite: begin
                udc_ncs          = 1'b0;
                udc_nwr          = 1'b0;
                udc_doe          = 1'b1;
                udc_dout         = sel_byte;
                {udc_a1, udc_a0} = sel;
            end
            StGap: begin
                udc_ncs          = 1'b0;
                {udc_a1, udc_a0} = 2'b11;
            end
            StRead: begin
                udc_ncs          = 1'b0;
                udc_nrd          = 1'b0;
                {udc_a1, udc_a0} = sel;
            end
            StStart: begin
                udc_ncs   = 1'b0;
                udc_start = 1'b1;
            end
            StWaitEc: udc_ncs  = 1'b0;
            StDone:   job_done = 1'b1;
            StFail:   job_fail = !cnt_q[0];
            default: ;
        endcase
    end

    assign busy      = (state_q != StIdle);
    assign fail_code = fail_code_q;
    assign udc_reset = udc_reset_q;
endmodule
